// File: rtl/muldiv_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_arbiter_pkg
//   Shared definitions for the mul/div arbiter: FSM state encoding, operation
//   codes for the unit's muordi input, and the operand/result widths.
// -----------------------------------------------------------------------------
package muldiv_arbiter_pkg;

  localparam int OP1_W = 32;  // opera1: divisor / multiplier
  localparam int OP2_W = 64;  // opera2: dividend / multiplicand
  localparam int RES_W = 64;  // unit result

  localparam logic MD_MUL = 1'b0;
  localparam logic MD_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// muldiv_arbiter_rr_arb2
//   Two-input round-robin picker (the rr_arb2 block of the arbiter).
//   Ports:
//     req0, req1  in   pending requests
//     last_grant  in   port granted most recently
//     gnt_valid   out  at least one request is pending
//     gnt_id      out  winning port (meaningful only when gnt_valid)
// -----------------------------------------------------------------------------
module muldiv_arbiter_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic gnt_valid,
  output logic gnt_id
);

  assign gnt_valid = req0 | req1;
  // On contention the port that did not win last time goes next; otherwise
  // the single requester wins (req1 alone selects port 1).
  assign gnt_id    = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// muldiv_arbiter
//   Shares one signed mul/div unit between two requesters. Picks a winner
//   round-robin, latches its operands, runs the unit's start/valid handshake
//   under a watchdog and returns the result with a one-cycle done pulse.
//   Ports:
//     clock, reset          clock (rising edge), synchronous active-high reset
//     req/op/a/b 0 and 1    per-port request, operation (1 = div), operands
//     ack0/ack1             one-cycle pulse: operands captured
//     done0/done1           one-cycle pulse: res/err valid for that port
//     res, err              last result; err = 1 marks a watchdog abort
//     busy                  FSM not in IDLE
//     du_*                  start/operands to the unit, result/valid back
// -----------------------------------------------------------------------------
module muldiv_arbiter
  import muldiv_arbiter_pkg::*;
#(
  parameter int unsigned      CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = 16'd200
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic             op0,
  input  logic [OP1_W-1:0] a0,
  input  logic [OP2_W-1:0] b0,
  output logic             ack0,
  output logic             done0,
  input  logic             req1,
  input  logic             op1,
  input  logic [OP1_W-1:0] a1,
  input  logic [OP2_W-1:0] b1,
  output logic             ack1,
  output logic             done1,
  output logic [RES_W-1:0] res,
  output logic             err,
  output logic             busy,
  output logic             du_start,
  output logic             du_muordi,
  output logic [OP1_W-1:0] du_opera1,
  output logic [OP2_W-1:0] du_opera2,
  input  logic [RES_W-1:0] du_result,
  input  logic             du_valid
);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;
  logic               last_grant_q, last_grant_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d, wdog_inc;
  logic               ack0_q, ack0_d, ack1_q, ack1_d;
  logic               done0_q, done0_d, done1_q, done1_d;
  logic [RES_W-1:0]   res_q, res_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               du_start_q, du_start_d;
  logic               du_muordi_q, du_muordi_d;
  logic [OP1_W-1:0]   du_opera1_q, du_opera1_d;
  logic [OP2_W-1:0]   du_opera2_q, du_opera2_d;
  logic               gnt_valid, gnt_id;

  muldiv_arbiter_rr_arb2 u_rr_arb2 (
    .req0       (req0),
    .req1       (req1),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // NOTE: every variable gets a default at the top of this block so that no
  // path through the case leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    wdog_inc     = wdog_q + CNT_W'(1);
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    res_d        = res_q;
    err_d        = err_q;
    du_muordi_d  = du_muordi_q;
    du_opera1_d  = du_opera1_q;
    du_opera2_d  = du_opera2_q;

    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          owner_d      = gnt_id;
          last_grant_d = gnt_id;
          du_muordi_d  = gnt_id ? op1 : op0;
          du_opera1_d  = gnt_id ? a1  : a0;
          du_opera2_d  = gnt_id ? b1  : b0;
          ack0_d       = ~gnt_id;
          ack1_d       = gnt_id;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        wdog_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        // A valid seen in the first RUN cycle may be left over from the
        // previous operation, so it only counts once wdog has advanced.
        // Completion is tested before the timeout so it wins a tie.
        if (du_valid && (wdog_q != '0)) begin
          res_d   = du_result;
          err_d   = 1'b0;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = DONE;
        end else if (wdog_inc == TIMEOUT) begin
          res_d   = '0;
          err_d   = 1'b1;
          done0_d = ~owner_q;
          done1_d = owner_q;
          state_d = DONE;
        end else begin
          wdog_d = wdog_inc;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Both flags follow the next state, keeping them registered and aligned.
    busy_d     = (state_d != IDLE);
    du_start_d = (state_d != RUN);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      res_q        <= '0;
      err_q        <= 1'b0;
      busy_q       <= 1'b0;
      du_start_q   <= 1'b1;
      du_muordi_q  <= 1'b0;
      du_opera1_q  <= '0;
      du_opera2_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      res_q        <= res_d;
      err_q        <= err_d;
      busy_q       <= busy_d;
      du_start_q   <= du_start_d;
      du_muordi_q  <= du_muordi_d;
      du_opera1_q  <= du_opera1_d;
      du_opera2_q  <= du_opera2_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign res       = res_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign du_start  = du_start_q;
  assign du_muordi = du_muordi_q;
  assign du_opera1 = du_opera1_q;
  assign du_opera2 = du_opera2_q;

endmodule

// File: tb/tb_muldiv_arbiter.sv
// -----------------------------------------------------------------------------
// tb_muldiv_arbiter
//   Directed bench for muldiv_arbiter. u_dut uses the default TIMEOUT with a
//   behavioural unit that answers a fixed number of cycles after start drops;
//   u_dut_to uses TIMEOUT = 10 with a unit that never answers.
// -----------------------------------------------------------------------------
module tb_muldiv_arbiter;
  import muldiv_arbiter_pkg::*;

  logic        clock, reset;
  logic        req0, op0, req1, op1;
  logic [31:0] a0, a1;
  logic [63:0] b0, b1;
  logic        ack0, done0, ack1, done1, err, busy;
  logic [63:0] res;
  logic        du_start, du_muordi, du_valid;
  logic [31:0] du_opera1;
  logic [63:0] du_opera2, du_result;

  // timeout instance
  logic        to_req0, to_req1;
  logic        to_ack0, to_done0, to_ack1, to_done1, to_err, to_busy;
  logic [63:0] to_res;
  logic        to_du_start, to_du_muordi;
  logic [31:0] to_du_opera1;
  logic [63:0] to_du_opera2;
  logic [63:0] to_du_result;
  logic        to_du_valid;

  int n_tests = 0;
  int n_fail  = 0;

  muldiv_arbiter u_dut (
    .clock(clock), .reset(reset),
    .req0(req0), .op0(op0), .a0(a0), .b0(b0), .ack0(ack0), .done0(done0),
    .req1(req1), .op1(op1), .a1(a1), .b1(b1), .ack1(ack1), .done1(done1),
    .res(res), .err(err), .busy(busy),
    .du_start(du_start), .du_muordi(du_muordi), .du_opera1(du_opera1),
    .du_opera2(du_opera2), .du_result(du_result), .du_valid(du_valid)
  );

  muldiv_arbiter #(.TIMEOUT(16'd10)) u_dut_to (
    .clock(clock), .reset(reset),
    .req0(to_req0), .op0(MD_DIV), .a0(32'd3), .b0(64'd9), .ack0(to_ack0), .done0(to_done0),
    .req1(to_req1), .op1(MD_MUL), .a1(32'd1), .b1(64'd1), .ack1(to_ack1), .done1(to_done1),
    .res(to_res), .err(to_err), .busy(to_busy),
    .du_start(to_du_start), .du_muordi(to_du_muordi), .du_opera1(to_du_opera1),
    .du_opera2(to_du_opera2), .du_result(to_du_result), .du_valid(to_du_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural unit: counts cycles with start low, raises valid when the
  // count equals unit_lat. stale_mode forces valid high permanently.
  int unsigned unit_cnt;
  int unsigned unit_lat;
  bit          stale_mode;
  logic [63:0] div_q, div_r;

  always @(posedge clock) begin
    if (du_start) unit_cnt <= 0;
    else          unit_cnt <= unit_cnt + 1;
  end

  always_comb begin
    div_q = '0;
    div_r = '0;
    if (du_opera1 != 32'd0) begin
      div_q = du_opera2 / {32'd0, du_opera1};
      div_r = du_opera2 % {32'd0, du_opera1};
    end
    du_result = du_muordi ? {div_r[31:0], div_q[31:0]} : du_opera2 * {32'd0, du_opera1};
    du_valid  = stale_mode || (!du_start && unit_cnt == unit_lat);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_ack0"},      64'(ack0),      64'd0);
    check({pfx, "_ack1"},      64'(ack1),      64'd0);
    check({pfx, "_done0"},     64'(done0),     64'd0);
    check({pfx, "_done1"},     64'(done1),     64'd0);
    check({pfx, "_res"},       res,            64'd0);
    check({pfx, "_err"},       64'(err),       64'd0);
    check({pfx, "_busy"},      64'(busy),      64'd0);
    check({pfx, "_du_start"},  64'(du_start),  64'd1);
    check({pfx, "_du_muordi"}, 64'(du_muordi), 64'd0);
    check({pfx, "_du_opera1"}, 64'(du_opera1), 64'd0);
    check({pfx, "_du_opera2"}, du_opera2,      64'd0);
  endtask

  // Called in the LOAD cycle; returns in the DONE cycle or when the budget
  // runs out. Counts RUN cycles and any operand movement on the du_* bus.
  task automatic wait_done(input int budget, output int low_cycles, output int op_changes);
    logic [31:0] o1;
    logic [63:0] o2;
    logic        m;
    low_cycles = 0;
    op_changes = 0;
    o1 = du_opera1;
    o2 = du_opera2;
    m  = du_muordi;
    for (int i = 0; i < budget && !(done0 || done1); i++) begin
      if (!du_start) low_cycles++;
      if (du_opera1 !== o1 || du_opera2 !== o2 || du_muordi !== m) op_changes++;
      tick();
    end
    if (du_opera1 !== o1 || du_opera2 !== o2 || du_muordi !== m) op_changes++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int low, chg, n_acks, n_done, last_done, owner, both, g;
    reset = 1'b1;
    req0 = 0; op0 = 0; a0 = 0; b0 = 0;
    req1 = 0; op1 = 0; a1 = 0; b1 = 0;
    to_req0 = 0; to_req1 = 0;
    to_du_valid = 1'b0;
    to_du_result = 64'hDEAD_BEEF_0123_4567;
    unit_lat = 40;
    stale_mode = 0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;

    // ---- single divide request on port 0, with operand isolation ----
    req0 = 1; op0 = MD_DIV; a0 = 32'd7; b0 = 64'd100;
    tick();
    check("single_ack0",   64'(ack0),      64'd1);
    check("single_ack1",   64'(ack1),      64'd0);
    check("single_busy",   64'(busy),      64'd1);
    check("single_opera1", 64'(du_opera1), 64'd7);
    check("single_opera2", du_opera2,      64'd100);
    check("single_muordi", 64'(du_muordi), 64'd1);
    check("single_load_start", 64'(du_start), 64'd1);
    req0 = 0; a0 = 32'd99; b0 = 64'd555;
    wait_done(300, low, chg);
    check("single_done0",    64'(done0),    64'd1);
    check("single_done1",    64'(done1),    64'd0);
    check("single_run_len",  64'(low),      64'd41);
    check("single_op_moved", 64'(chg),      64'd0);
    check("single_res",      res,           64'h0000_0002_0000_000E);
    check("single_err",      64'(err),      64'd0);
    check("single_restart",  64'(du_start), 64'd1);
    tick();
    check("single_done_pulse", 64'(done0), 64'd0);
    check("single_idle_busy",  64'(busy),  64'd0);
    check("single_res_hold",   res,        64'h0000_0002_0000_000E);

    // ---- contention: both ports requesting from the cycle after reset ----
    reset = 1'b1;
    tick();
    reset = 1'b0;
    unit_lat = 3;
    req0 = 1; op0 = MD_MUL; a0 = 32'd3; b0 = 64'd5;
    req1 = 1; op1 = MD_DIV; a1 = 32'd4; b1 = 64'd30;
    n_acks = 0; n_done = 0; last_done = 0; owner = 0; both = 0;
    for (int c = 0; c < 200 && n_done < 4; c++) begin
      tick();
      if ((ack0 && ack1) || (done0 && done1)) both++;
      if (ack0 || ack1) begin
        g = ack1 ? 1 : 0;
        check($sformatf("cont_grant%0d", n_acks), 64'(g), 64'(n_acks % 2));
        if (n_acks > 0) check($sformatf("cont_gap%0d", n_acks), 64'(c - last_done), 64'd2);
        owner = g;
        n_acks++;
      end
      if (done0 || done1) begin
        check($sformatf("cont_owner%0d", n_done), 64'(done1), 64'(owner));
        check($sformatf("cont_res%0d", n_done), res,
              (owner == 1) ? 64'h0000_0002_0000_0007 : 64'd15);
        last_done = c;
        n_done++;
      end
    end
    req0 = 0; req1 = 0;
    check("cont_ops",  64'(n_done), 64'd4);
    check("cont_dual", 64'(both),   64'd0);
    tick();
    tick();

    // ---- stale valid held high on entry to RUN ----
    stale_mode = 1;
    req1 = 1; op1 = MD_MUL; a1 = 32'd6; b1 = 64'd7;
    tick();
    check("stale_ack1", 64'(ack1), 64'd1);
    req1 = 0;
    wait_done(50, low, chg);
    check("stale_done1",   64'(done1), 64'd1);
    check("stale_run_len", 64'(low),   64'd2);
    check("stale_res",     res,        64'd42);
    check("stale_err",     64'(err),   64'd0);
    stale_mode = 0;
    tick();

    // ---- watchdog timeout on the TIMEOUT = 10 instance ----
    to_req0 = 1;
    tick();
    check("to_ack0", 64'(to_ack0), 64'd1);
    to_req0 = 0;
    low = 0;
    for (int i = 0; i < 100 && !(to_done0 || to_done1); i++) begin
      if (!to_du_start) low++;
      tick();
    end
    check("to_done0",    64'(to_done0),    64'd1);
    check("to_done1",    64'(to_done1),    64'd0);
    check("to_run_len",  64'(low),         64'd10);
    check("to_err",      64'(to_err),      64'd1);
    check("to_res",      to_res,           64'd0);
    check("to_du_start", 64'(to_du_start), 64'd1);
    tick();
    check("to_idle_busy", 64'(to_busy), 64'd0);

    // ---- reset in the 5th RUN cycle ----
    unit_lat = 40;
    req0 = 1; op0 = MD_MUL; a0 = 32'd2; b0 = 64'd3;
    tick();
    check("midrst_ack0", 64'(ack0), 64'd1);
    req0 = 0;
    tick();
    repeat (4) tick();
    check("midrst_in_run", 64'(du_start), 64'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_vals("midrst");
    n_done = 0;
    repeat (5) begin
      tick();
      if (done0 || done1) n_done++;
    end
    check("midrst_no_done", 64'(n_done), 64'd0);
    req1 = 1; op1 = MD_DIV; a1 = 32'd5; b1 = 64'd47;
    tick();
    check("midrst_ack1", 64'(ack1), 64'd1);
    check("midrst_ack0", 64'(ack0), 64'd0);
    req1 = 0;
    wait_done(300, low, chg);
    check("midrst_done1",   64'(done1), 64'd1);
    check("midrst_run_len", 64'(low),   64'd41);
    check("midrst_res",     res,        64'h0000_0002_0000_0009);
    check("midrst_err",     64'(err),   64'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_arbiter.md
Name: muldiv_arbiter

Overview:
- Shares one signed multiplier/divider unit between two requesters (port 0, port 1).
- Uses round-robin arbitration and latches the winner's operands.
- Sequences the unit's start/valid protocol and returns the 64-bit result with a one-cycle done pulse to the owning requester.
- Sits between the issue logic and the existing mul/div unit, and adds a watchdog timeout so that a stalled unit cannot hang either requester.

Parameters:
- TIMEOUT, 16'd200: maximum RUN cycles to wait for du_valid before aborting with err.
- CNT_W, 16: width of the watchdog counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req0  in  1  port 0 request; held high until ack0
- op0  in  1  port 0 operation (muordi): 1 = divide, 0 = multiply
- a0  in  32  port 0 opera1 (divisor / multiplier)
- b0  in  64  port 0 opera2 (dividend / multiplicand)
- ack0  out  1  one-cycle pulse: port 0 request accepted, operands captured
- done0  out  1  one-cycle pulse: port 0 result valid on res
- req1, op1, a1, b1, ack1, done1: same as port 0, for port 1
- res  out  64  result of the most recently completed operation
- err  out  1  qualifies done0/done1: 1 = timeout abort, res = 0
- busy  out  1  1 when state is not IDLE
- du_start  out  1  unit start (1 = hold unit cleared in its idle state)
- du_muordi  out  1  latched operation to the unit
- du_opera1  out  32  latched opera1 to the unit
- du_opera2  out  64  latched opera2 to the unit
- du_result  in  64  unit result
- du_valid  in  1  unit completion flag

Behaviour:
- Reset values:
  - Outputs: ack0/1 = 0, done0/1 = 0, res = 0, err = 0, busy = 0, du_start = 1, du_muordi = 0, du_opera1 = 0, du_opera2 = 0.
  - Internal: state = IDLE, last_grant = 1 (so port 0 wins first), wdog = 0.
- du_start rule: du_start = 0 only in RUN; it is 1 in every other state and during reset. Holding start high keeps the unit parked and cleared.
- States: IDLE, LOAD, RUN, DONE. All outputs are registered.
- IDLE:
  - Neither request high: stay in IDLE.
  - Only one request high: grant that port.
  - Both high: grant the port that is not last_grant.
  - On grant: latch that port's op/a/b into du_*, set owner and last_grant to that port, go to LOAD.
- LOAD (1 cycle):
  - ack of the owner = 1; du_start = 1 with the latched operands stable; wdog cleared.
  - Next state is RUN. The requester may drop req or change operands after ack.
- RUN:
  - du_start = 0; du_* operands held constant; wdog increments each cycle.
  - du_valid is ignored in the first RUN cycle (wdog == 0) to mask any stale valid.
  - Sample du_valid == 1 with wdog >= 1: latch res = du_result, err = 0, go to DONE.
  - wdog reaches TIMEOUT: res = 0, err = 1, go to DONE. du_valid is checked before TIMEOUT in the same cycle (completion wins).
- DONE (1 cycle):
  - done of the owner = 1; err valid; du_start = 1 (unit re-parked); next state IDLE.
  - res and err hold their values until the next DONE.
- Latency:
  - req sampled high in IDLE -> ack 1 cycle later -> earliest done at LOAD + 3 cycles.
  - Overall latency = 3 + unit compute cycles.
- Back-to-back and fairness:
  - A request present in the IDLE cycle after DONE is granted then, i.e. one idle cycle between operations.
  - With both ports requesting continuously, grants strictly alternate.
- A req that stays high after its own done counts as a new request.
- ack and done are never asserted on both ports in the same cycle.
- Reset mid-operation: the next edge forces IDLE and all reset values. The partial result is discarded, no done pulse is produced, and du_start = 1 clears the unit.
- The block never compares widths: operands pass through unchanged; sign handling belongs to the unit.

Decomposition:
- Shared package: state encoding constants (IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3), MD_MUL = 1'b0, MD_DIV = 1'b1, and the operand widths 32/64.
- One natural sub-module, rr_arb2: a 2-input round-robin picker (inputs req0, req1, last_grant; outputs gnt_valid, gnt_id).
- Everything else stays in the top FSM.

Test Plan:
- Single request: req0 = 1, op0 = 1, a0 = 7, b0 = 100, unit model returns {rem 2, quot 14} after 40 cycles. Expect:
  - ack0 exactly 1 cycle after req0 is sampled;
  - du_start low for 41 cycles;
  - done0 = 1 with res = {32'd2, 32'd14} and err = 0; done1 never asserts.
- Contention: req0 and req1 high from the cycle after reset. Expect grant order 0, 1, 0, 1 over four operations, with exactly one IDLE cycle between each DONE and the next LOAD.
- Stale valid: the unit model holds du_valid = 1 on entering RUN. Expect it to be ignored in the first RUN cycle and completion on the second RUN cycle only.
- Timeout: the unit model never asserts du_valid with TIMEOUT = 10. Expect done for the owner after 10 RUN cycles, err = 1, res = 0, and du_start back to 1.
- Reset mid-RUN: assert reset for 1 cycle in the 5th RUN cycle. Expect:
  - state IDLE and all outputs at reset values on the next edge;
  - no done pulse;
  - a subsequent req1 is served normally with port 0 priority restored (last_grant = 1).
- Operand isolation: change a0/b0 the cycle after ack0. Expect du_opera1/du_opera2 unchanged until DONE.
